// File: rtl/mem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM state encoding, DMA size codes
// and default parameter values.
package mem_arb_pkg;

  typedef enum logic {
    S_CORE  = 1'b0,
    S_FORCE = 1'b1
  } arb_state_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned DEFAULT_STARVE_LIMIT = 4;
  localparam int unsigned DEFAULT_MEM_BYTES    = 1 << 20;

  // Byte count of a DMA access; the illegal code maps to 0.
  function automatic logic [2:0] size_bytes(logic [1:0] size);
    case (size)
      SZ_BYTE: return 3'd1;
      SZ_HALF: return 3'd2;
      SZ_WORD: return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/mem_data_arbiter_if.sv
// Bus bundle between the core MEM stage, the DMA/debug master, the data memory and the
// arbiter. The arbiter uses the slave view; the environment uses the master view.
interface mem_data_arbiter_if;
  logic        core_req;
  logic        core_we;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic        core_store_byte;
  logic        core_store_half;
  logic [31:0] core_rdata;
  logic        core_stall;

  logic        dma_valid;
  logic        dma_we;
  logic [31:0] dma_addr;
  logic [31:0] dma_wdata;
  logic [1:0]  dma_size;
  logic        dma_ready;
  logic        dma_rvalid;
  logic [31:0] dma_rdata;
  logic        dma_err;

  logic        mem_write;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        store_byte;
  logic        store_half;
  logic [31:0] mem_rdata;

  modport slave (
    input  core_req, core_we, core_addr, core_wdata, core_store_byte, core_store_half,
    output core_rdata, core_stall,
    input  dma_valid, dma_we, dma_addr, dma_wdata, dma_size,
    output dma_ready, dma_rvalid, dma_rdata, dma_err,
    output mem_write, mem_addr, mem_wdata, store_byte, store_half,
    input  mem_rdata
  );

  modport master (
    output core_req, core_we, core_addr, core_wdata, core_store_byte, core_store_half,
    input  core_rdata, core_stall,
    output dma_valid, dma_we, dma_addr, dma_wdata, dma_size,
    input  dma_ready, dma_rvalid, dma_rdata, dma_err,
    input  mem_write, mem_addr, mem_wdata, store_byte, store_half,
    output mem_rdata
  );
endinterface

// File: rtl/mem_arb_dma_check.sv
// Combinational legality check of a DMA access: size code, natural alignment and
// whether the access fits inside the data memory.
module mem_arb_dma_check
  import mem_arb_pkg::*;
#(
  parameter int unsigned MEM_BYTES = DEFAULT_MEM_BYTES
) (
  input  logic [31:0] i_addr,
  input  logic [1:0]  i_size,
  output logic        o_err
);

  logic [32:0] end_addr;
  logic        misaligned;

  always_comb begin
    // 33-bit sum so addresses near 2^32 cannot wrap past the range check.
    end_addr = {1'b0, i_addr} + {30'd0, size_bytes(i_size)};
    case (i_size)
      SZ_BYTE: misaligned = 1'b0;
      SZ_HALF: misaligned = i_addr[0];
      SZ_WORD: misaligned = |i_addr[1:0];
      default: misaligned = 1'b1;
    endcase
    o_err = misaligned | (end_addr > 33'(MEM_BYTES));
  end

endmodule

// File: rtl/mem_data_arbiter.sv
// Data-memory arbiter between the core MEM stage and a DMA/debug master. The core has
// priority; a DMA request starved for STARVE_LIMIT cycles gets one forced slot.
module mem_data_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = DEFAULT_STARVE_LIMIT,
  parameter int unsigned MEM_BYTES    = DEFAULT_MEM_BYTES
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_clk_enable,
  mem_data_arbiter_if.slave   bus
);

  arb_state_e  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        rvalid_q, rvalid_d;
  logic        err_q, err_d;
  logic [31:0] rdata_q, rdata_d;

  logic dma_err;
  logic active;
  logic dma_ready;
  logic core_stall;
  logic xfer;

  mem_arb_dma_check #(
    .MEM_BYTES(MEM_BYTES)
  ) u_dma_check (
    .i_addr(bus.dma_addr),
    .i_size(bus.dma_size),
    .o_err (dma_err)
  );

  always_comb begin
    // No handshake or write may happen while frozen or in a reset cycle.
    active     = i_clk_enable & ~i_rst;
    dma_ready  = active & ((state_q == S_FORCE) | ~bus.core_req);
    core_stall = i_clk_enable & (state_q == S_FORCE) & bus.core_req;
    xfer       = bus.dma_valid & dma_ready;

    if (xfer) begin
      bus.mem_addr   = bus.dma_addr;
      bus.mem_wdata  = bus.dma_wdata;
      bus.store_byte = (bus.dma_size == SZ_BYTE);
      bus.store_half = (bus.dma_size == SZ_HALF);
      bus.mem_write  = bus.dma_we & ~dma_err;
    end else begin
      bus.mem_addr   = bus.core_addr;
      bus.mem_wdata  = bus.core_wdata;
      bus.store_byte = bus.core_store_byte;
      bus.store_half = bus.core_store_half & ~bus.core_store_byte;
      bus.mem_write  = active & bus.core_req & bus.core_we & ~core_stall;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    rvalid_d = rvalid_q;
    err_d    = err_q;
    rdata_d  = rdata_q;
    if (i_clk_enable) begin
      if (xfer || !bus.dma_valid) begin
        cnt_d = 4'd0;
      end else if (cnt_q != 4'hF) begin
        cnt_d = cnt_q + 4'd1;
      end
      if (state_q == S_FORCE) begin
        state_d = S_CORE;
      end else if (cnt_d >= 4'(STARVE_LIMIT)) begin
        state_d = S_FORCE;
      end
      rvalid_d = xfer;
      if (xfer) begin
        err_d   = dma_err;
        rdata_d = (bus.dma_we || dma_err) ? 32'd0 : bus.mem_rdata;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= S_CORE;
      cnt_q    <= 4'd0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      rdata_q  <= 32'd0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
    end
  end

  // A response pending across a reset edge is dropped rather than strobed.
  assign bus.dma_rvalid = rvalid_q & ~i_rst;
  assign bus.dma_err    = err_q & ~i_rst;
  assign bus.dma_rdata  = rdata_q;
  assign bus.dma_ready  = dma_ready;
  assign bus.core_stall = core_stall;
  assign bus.core_rdata = bus.mem_rdata;

endmodule

// File: tb/tb_mem_data_arbiter.sv
// Directed and randomized bench for mem_data_arbiter, checked against a cycle-level
// reference model of the arbitration rules and a reference copy of memory.
module tb_mem_data_arbiter;
  import mem_arb_pkg::*;

  localparam int unsigned LIMIT = 4;
  localparam int unsigned MEMB  = 1 << 20;

  logic clk = 1'b0;
  logic rst;
  logic en;
  always #5 clk = ~clk;

  mem_data_arbiter_if bus ();

  mem_data_arbiter #(
    .STARVE_LIMIT(LIMIT),
    .MEM_BYTES   (MEMB)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_clk_enable(en),
    .bus         (bus)
  );

  logic [31:0] env_mem [0:1023];
  logic [31:0] ref_mem [0:1023];

  function automatic logic [31:0] merge(logic [31:0] old, logic [1:0] lane, logic [31:0] data,
                                        logic b, logic h);
    logic [31:0] r;
    int l;
    r = old;
    l = int'(lane);
    if (b) r[l*8 +: 8] = data[7:0];
    else if (h) r[(l/2)*16 +: 16] = data[15:0];
    else r = data;
    return r;
  endfunction

  assign bus.mem_rdata = env_mem[bus.mem_addr[11:2]];

  always @(posedge clk) begin
    if (bus.mem_write) begin
      env_mem[bus.mem_addr[11:2]] <= merge(env_mem[bus.mem_addr[11:2]], bus.mem_addr[1:0],
                                           bus.mem_wdata, bus.store_byte, bus.store_half);
    end
  end

  int n_cmp  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Reference model state
  bit          m_force;
  int          m_streak;
  bit          m_rvalid;
  bit          m_err;
  logic [31:0] m_rdata;
  bit          last_xfer;

  logic        obs_ready, obs_stall, obs_rvalid, obs_err, obs_write;
  logic [31:0] obs_rdata, obs_core_rdata;

  task automatic step(input bit r, input bit e, input bit creq, input bit cwe,
                      input logic [31:0] caddr, input logic [31:0] cwd, input bit cb,
                      input bit ch, input bit dv, input bit dwe, input logic [31:0] daddr,
                      input logic [31:0] dwd, input logic [1:0] dsz);
    bit          xf, derr, ex_ready, ex_stall, ex_write, ex_b, ex_h;
    int          nbytes;
    logic [31:0] ex_addr, ex_data, rword;
    rst = r;
    en  = e;
    bus.core_req        = creq;
    bus.core_we         = cwe;
    bus.core_addr       = caddr;
    bus.core_wdata      = cwd;
    bus.core_store_byte = cb;
    bus.core_store_half = ch;
    bus.dma_valid       = dv;
    bus.dma_we          = dwe;
    bus.dma_addr        = daddr;
    bus.dma_wdata       = dwd;
    bus.dma_size        = dsz;
    @(negedge clk);

    if (dsz == 2'b11) begin
      derr = 1'b1;
    end else begin
      nbytes = 1 << dsz;
      derr = ((daddr % nbytes) != 0) || (longint'(daddr) + longint'(nbytes) > longint'(MEMB));
    end
    ex_ready = !r && e && (m_force || !creq);
    ex_stall = e && m_force && creq;
    xf       = dv && ex_ready;
    ex_write = !r && e && (xf ? (dwe && !derr) : (creq && cwe && !ex_stall));
    ex_addr  = xf ? daddr : caddr;
    ex_data  = xf ? dwd : cwd;
    ex_b     = xf ? (dsz == 2'b00) : cb;
    ex_h     = xf ? (dsz == 2'b01) : (ch && !cb);

    obs_ready      = bus.dma_ready;
    obs_stall      = bus.core_stall;
    obs_rvalid     = bus.dma_rvalid;
    obs_err        = bus.dma_err;
    obs_rdata      = bus.dma_rdata;
    obs_write      = bus.mem_write;
    obs_core_rdata = bus.core_rdata;

    chk("dma_ready", 32'(obs_ready), 32'(ex_ready));
    chk("core_stall", 32'(obs_stall), 32'(ex_stall));
    chk("mem_write", 32'(obs_write), 32'(ex_write));
    chk("mem_addr", bus.mem_addr, ex_addr);
    chk("dma_rvalid", 32'(obs_rvalid), 32'(m_rvalid && !r));
    if (m_rvalid && !r) begin
      chk("dma_err", 32'(obs_err), 32'(m_err));
      chk("dma_rdata", obs_rdata, m_rdata);
    end
    if (ex_write) begin
      chk("mem_wdata", bus.mem_wdata, ex_data);
      chk("store_byte", 32'(bus.store_byte), 32'(ex_b));
      chk("store_half", 32'(bus.store_half), 32'(ex_h));
    end
    if (e && !r && creq && !cwe && !ex_stall) begin
      chk("core_rdata", obs_core_rdata, ref_mem[caddr[11:2]]);
    end

    rword = ref_mem[daddr[11:2]];
    if (ex_write) ref_mem[ex_addr[11:2]] = merge(ref_mem[ex_addr[11:2]], ex_addr[1:0], ex_data,
                                                 ex_b, ex_h);
    if (r) begin
      m_force  = 1'b0;
      m_streak = 0;
      m_rvalid = 1'b0;
      m_err    = 1'b0;
      m_rdata  = '0;
    end else if (e) begin
      if (xf || !dv) m_streak = 0;
      else if (m_streak < 15) m_streak++;
      m_force  = !m_force && (m_streak >= int'(LIMIT));
      m_rvalid = xf;
      if (xf) begin
        m_err   = derr;
        m_rdata = (dwe || derr) ? 32'd0 : rword;
      end
    end
    last_xfer = xf;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    step(0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 2'b10);
  endtask

  task automatic core(input bit we, input logic [31:0] a, input logic [31:0] d);
    step(0, 1, 1, we, a, d, 0, 0, 0, 0, 32'h0, 32'h0, 2'b10);
  endtask

  task automatic dma(input bit we, input logic [31:0] a, input logic [31:0] d,
                     input logic [1:0] sz);
    step(0, 1, 0, 0, 32'h0, 32'h0, 0, 0, 1, we, a, d, sz);
  endtask

  initial begin
    bit          pv, pwe, r, e, creq, cwe, cb, ch;
    logic [31:0] pa, pd, caddr;
    logic [1:0]  ps;
    int          ct;

    for (int i = 0; i < 1024; i++) begin
      env_mem[i] = '0;
      ref_mem[i] = '0;
    end
    m_force = 0; m_streak = 0; m_rvalid = 0; m_err = 0; m_rdata = '0;
    rst = 1'b1;
    en  = 1'b1;
    @(posedge clk);
    #1;

    // Reset
    step(1, 1, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 2'b10);
    step(1, 1, 0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 32'h0, 32'h0, 2'b10);
    idle();
    chk("reset_rvalid", 32'(obs_rvalid), 32'd0);
    chk("reset_stall", 32'(obs_stall), 32'd0);

    // Core-only store then load
    core(1, 32'h100, 32'hDEADBEEF);
    chk("core_st_stall", 32'(obs_stall), 32'd0);
    core(0, 32'h100, 32'h0);
    chk("core_ld_stall", 32'(obs_stall), 32'd0);
    chk("core_ld_data", obs_core_rdata, 32'hDEADBEEF);

    // DMA write with core idle, then core load of the written word
    dma(1, 32'h200, 32'h12345678, SZ_WORD);
    chk("dma_wr_ready", 32'(obs_ready), 32'd1);
    idle();
    chk("dma_wr_rvalid", 32'(obs_rvalid), 32'd1);
    chk("dma_wr_err", 32'(obs_err), 32'd0);
    core(0, 32'h200, 32'h0);
    chk("core_ld_dma_data", obs_core_rdata, 32'h12345678);

    // Starvation: four blocked cycles then a forced slot
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 1, 0, 32'h100, 32'h0, 0, 0, 1, 0, 32'h200, 32'h0, SZ_WORD);
      chk("starve_blocked", 32'(obs_ready), 32'd0);
    end
    step(0, 1, 1, 0, 32'h100, 32'h0, 0, 0, 1, 0, 32'h200, 32'h0, SZ_WORD);
    chk("force_stall", 32'(obs_stall), 32'd1);
    chk("force_ready", 32'(obs_ready), 32'd1);
    core(0, 32'h100, 32'h0);
    chk("force_rvalid", 32'(obs_rvalid), 32'd1);
    chk("force_rdata", obs_rdata, 32'h12345678);
    chk("after_force_stall", 32'(obs_stall), 32'd0);
    chk("after_force_ready", 32'(obs_ready), 32'd0);

    // Illegal DMA accesses
    dma(1, 32'h201, 32'hAAAA5555, SZ_HALF);
    chk("half_odd_write", 32'(obs_write), 32'd0);
    idle();
    chk("half_odd_err", 32'(obs_err), 32'd1);
    chk("half_odd_rdata", obs_rdata, 32'd0);
    dma(1, 32'hFFFFE, 32'h11111111, SZ_WORD);
    chk("word_edge_write", 32'(obs_write), 32'd0);
    idle();
    chk("word_edge_err", 32'(obs_err), 32'd1);
    dma(1, 32'h300, 32'h22222222, 2'b11);
    chk("size11_write", 32'(obs_write), 32'd0);
    idle();
    chk("size11_err", 32'(obs_err), 32'd1);
    chk("size11_rvalid", 32'(obs_rvalid), 32'd1);
    dma(0, 32'h100000, 32'h0, SZ_WORD);
    idle();
    chk("range_err", 32'(obs_err), 32'd1);

    // Reset right after a transfer drops the response; store during reset is suppressed
    dma(1, 32'h300, 32'hCAFEF00D, SZ_WORD);
    step(1, 1, 1, 1, 32'h304, 32'h55, 0, 0, 0, 0, 32'h0, 32'h0, SZ_WORD);
    chk("rst_no_rvalid", 32'(obs_rvalid), 32'd0);
    chk("rst_no_write", 32'(obs_write), 32'd0);
    idle();
    chk("post_rst_rvalid", 32'(obs_rvalid), 32'd0);

    // Clock enable low freezes the starvation counter and blocks grants
    for (int i = 0; i < 2; i++)
      step(0, 1, 1, 0, 32'h100, 32'h0, 0, 0, 1, 1, 32'h304, 32'h77, SZ_WORD);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 1, 32'h100, 32'h99, 0, 0, 1, 1, 32'h304, 32'h77, SZ_WORD);
      chk("dis_ready", 32'(obs_ready), 32'd0);
      chk("dis_write", 32'(obs_write), 32'd0);
      chk("dis_stall", 32'(obs_stall), 32'd0);
    end
    for (int i = 0; i < 2; i++) begin
      step(0, 1, 1, 0, 32'h100, 32'h0, 0, 0, 1, 1, 32'h304, 32'h77, SZ_WORD);
      chk("resume_blocked", 32'(obs_ready), 32'd0);
    end
    step(0, 1, 1, 0, 32'h100, 32'h0, 0, 0, 1, 1, 32'h304, 32'h77, SZ_WORD);
    chk("resume_force", 32'(obs_stall), 32'd1);
    idle();

    // Randomized traffic; DMA master holds its request until granted
    pv = 0; pwe = 0; pa = '0; pd = '0; ps = '0;
    for (int i = 0; i < 400; i++) begin
      if (!pv && ($urandom % 2 == 0)) begin
        pv  = 1;
        pwe = 1'($urandom % 2);
        ps  = 2'($urandom % 4);
        pa  = 32'($urandom_range(0, 4095));
        if ($urandom % 4 != 0) begin
          if (ps == SZ_HALF) pa[0] = 1'b0;
          if (ps == SZ_WORD) pa[1:0] = 2'b00;
        end
        pd = $urandom;
      end
      creq  = ($urandom % 10) < 6;
      cwe   = 1'($urandom % 2);
      ct    = int'($urandom % 3);
      cb    = (ct == 0);
      ch    = (ct == 1);
      caddr = 32'($urandom_range(0, 4095));
      if (ch) caddr[0] = 1'b0;
      if (!cb && !ch) caddr[1:0] = 2'b00;
      e = ($urandom % 8) != 0;
      r = ($urandom % 64) == 0;
      step(r, e, creq, cwe, caddr, $urandom, cb, ch, pv, pwe, pa, pd, ps);
      if (last_xfer || r) pv = 0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
